// File: rtl/sram_port_responder_pkg.sv
// rtl/sram_port_responder_pkg.sv - shared tag codes, return-word type, arbiter port enum, counter helper
// Contents:
//   INVALID_TAG / DATA_TAG0 / DATA_TAG1 / DATA_END_TAG  client read tag codes
//   ret_word_t   {tag, data} read-return word at default widths
//   port_t       round-robin pointer encoding
//   sat_inc      32-bit saturating increment

package sram_if_pkg;

    localparam logic [1:0] INVALID_TAG  = 2'd0;
    localparam logic [1:0] DATA_TAG0    = 2'd1;
    localparam logic [1:0] DATA_TAG1    = 2'd2;
    localparam logic [1:0] DATA_END_TAG = 2'd3;

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] data;
    } ret_word_t;

    // Port that wins the next tie between both requesters.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sram_port_responder_if.sv
// rtl/sram_port_responder_if.sv - two-channel request/ready/command_entry client bundle
// Signals:
//   client -> responder: request0/1, command_entry0/1, write_enable1, address0/1, tag0, data_out1
//   responder -> client: ready0/1, valid0, query0, qtag0
// Modports: master (client side), slave (responder side)

interface sram_port_responder_if #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int SRAMDATA_WIDTH = 32,
    parameter int TAG_WIDTH      = 2
);
    logic                      request0;
    logic                      request1;
    logic                      command_entry0;
    logic                      command_entry1;
    logic                      write_enable1;
    logic [ADDRESS_WIDTH-1:0]  address0;
    logic [ADDRESS_WIDTH-1:0]  address1;
    logic [TAG_WIDTH-1:0]      tag0;
    logic [SRAMDATA_WIDTH-1:0] data_out1;

    logic                      ready0;
    logic                      ready1;
    logic                      valid0;
    logic [SRAMDATA_WIDTH-1:0] query0;
    logic [TAG_WIDTH-1:0]      qtag0;

    modport master (
        output request0, request1, command_entry0, command_entry1, write_enable1,
        output address0, address1, tag0, data_out1,
        input  ready0, ready1, valid0, query0, qtag0
    );

    modport slave (
        input  request0, request1, command_entry0, command_entry1, write_enable1,
        input  address0, address1, tag0, data_out1,
        output ready0, ready1, valid0, query0, qtag0
    );

endinterface

// File: rtl/sram_port_responder_resp_delay_line.sv
// rtl/sram_port_responder_resp_delay_line.sv - {valid, tag} shift register aligned with SRAM read data
// Ports:
//   clock, clear            posedge clock; clear empties every stage
//   in_valid, in_tag        entry captured alongside the SRAM address register
//   out_valid, out_tag      entry emerging in the cycle its sram_rdata is valid
// DEPTH = SRAM_LATENCY + 1 (>= 2).

module resp_delay_line #(
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    output logic [TAG_WIDTH-1:0] out_tag
);

    logic [DEPTH-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_q [DEPTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/sram_port_responder.sv
// rtl/sram_port_responder.sv - arbitrates a tagged read port and a write port onto one single-port SRAM
// Ports:
//   clock, reset, refresh   posedge clock; reset and refresh both clear all state synchronously
//   bus                     sram_port_responder_if.slave client bundle
//   sram_addr/we/wdata      registered SRAM command
//   sram_rdata              SRAM read data, valid SRAM_LATENCY cycles after sram_addr
//   protocol_error          sticky: command_entry seen outside a granted slot
//   stat_reads/writes/idle_slots  saturating counters, only with SRAM_PORT_RESPONDER_STATS_EN
// Optional feature macro: SRAM_PORT_RESPONDER_STATS_EN

module sram_port_responder
    import sram_if_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int SRAMDATA_WIDTH = 32,
    parameter int TAG_WIDTH      = 2,
    parameter int MEM_ADDR_WIDTH = 18,
    parameter int SRAM_LATENCY   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      refresh,
    sram_port_responder_if.slave      bus,
    output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
    output logic                      sram_we,
    output logic [SRAMDATA_WIDTH-1:0] sram_wdata,
    input  logic [SRAMDATA_WIDTH-1:0] sram_rdata,
    output logic                      protocol_error
`ifdef SRAM_PORT_RESPONDER_STATS_EN
    ,
    output logic [31:0]               stat_reads,
    output logic [31:0]               stat_writes,
    output logic [31:0]               stat_idle_slots
`endif
);

    // Client addresses narrower than the SRAM are zero-extended, wider ones truncated.
    localparam int ADDR_KEEP = (MEM_ADDR_WIDTH < ADDRESS_WIDTH) ? MEM_ADDR_WIDTH : ADDRESS_WIDTH;

    logic clear;
    assign clear = reset | refresh;

    // ------------------------------------------------------------------
    // Grant arbiter: one grant per cycle, last-granted port loses ties.
    // ------------------------------------------------------------------
    port_t prio_q;
    logic  ready0_q, ready1_q;
    logic  slot0_q, slot1_q;
    logic  grant0_nxt, grant1_nxt;

    always_comb begin
        grant0_nxt = 1'b0;
        grant1_nxt = 1'b0;
        if (bus.request0 && bus.request1) begin
            grant0_nxt = (prio_q == PORT0);
            grant1_nxt = (prio_q == PORT1);
        end else begin
            grant0_nxt = bus.request0;
            grant1_nxt = bus.request1;
        end
    end

    // A grant in cycle t makes cycle t+1 the port's slot, even if request drops meanwhile.
    always_ff @(posedge clock) begin
        if (clear) begin
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            slot0_q  <= 1'b0;
            slot1_q  <= 1'b0;
            prio_q   <= PORT0;
        end else begin
            ready0_q <= grant0_nxt;
            ready1_q <= grant1_nxt;
            slot0_q  <= ready0_q;
            slot1_q  <= ready1_q;
            if (grant0_nxt) begin
                prio_q <= PORT1;
            end else if (grant1_nxt) begin
                prio_q <= PORT0;
            end
        end
    end

    assign bus.ready0 = ready0_q;
    assign bus.ready1 = ready1_q;

    // ------------------------------------------------------------------
    // Command acceptance and SRAM command register
    // ------------------------------------------------------------------
    logic accept_read;
    logic accept_write;
    logic stray_command;

    assign accept_read   = bus.command_entry0 & slot0_q;
    // A port-1 command without write_enable1 consumes its slot but touches nothing.
    assign accept_write  = bus.command_entry1 & slot1_q & bus.write_enable1;
    assign stray_command = (bus.command_entry0 & ~slot0_q) | (bus.command_entry1 & ~slot1_q);

    always_ff @(posedge clock) begin
        if (clear) begin
            sram_addr      <= '0;
            sram_we        <= 1'b0;
            sram_wdata     <= '0;
            protocol_error <= 1'b0;
        end else begin
            sram_we <= accept_write;
            if (accept_read) begin
                sram_addr <= MEM_ADDR_WIDTH'(bus.address0[ADDR_KEEP-1:0]);
            end else if (accept_write) begin
                sram_addr  <= MEM_ADDR_WIDTH'(bus.address1[ADDR_KEEP-1:0]);
                sram_wdata <= bus.data_out1;
            end
            if (stray_command) begin
                protocol_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: tag travels beside the SRAM pipeline, then one output stage.
    // ------------------------------------------------------------------
    logic                 dl_valid;
    logic [TAG_WIDTH-1:0] dl_tag;

    resp_delay_line #(
        .DEPTH     (SRAM_LATENCY + 1),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_resp_delay_line (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (accept_read),
        .in_tag    (bus.tag0),
        .out_valid (dl_valid),
        .out_tag   (dl_tag)
    );

    logic                      valid0_q;
    logic [SRAMDATA_WIDTH-1:0] query0_q;
    logic [TAG_WIDTH-1:0]      qtag0_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            valid0_q <= 1'b0;
            query0_q <= '0;
            qtag0_q  <= '0;
        end else begin
            valid0_q <= dl_valid;
            if (dl_valid) begin
                query0_q <= sram_rdata;
                qtag0_q  <= dl_tag;
            end
        end
    end

    assign bus.valid0 = valid0_q;
    assign bus.query0 = query0_q;
    assign bus.qtag0  = qtag0_q;

`ifdef SRAM_PORT_RESPONDER_STATS_EN
    // ------------------------------------------------------------------
    // Debug counters
    // ------------------------------------------------------------------
    logic slot_idle;
    assign slot_idle = (slot0_q & ~bus.command_entry0) | (slot1_q & ~bus.command_entry1);

    always_ff @(posedge clock) begin
        if (clear) begin
            stat_reads      <= '0;
            stat_writes     <= '0;
            stat_idle_slots <= '0;
        end else begin
            if (accept_read) begin
                stat_reads <= sat_inc(stat_reads);
            end
            if (accept_write) begin
                stat_writes <= sat_inc(stat_writes);
            end
            if (slot_idle) begin
                stat_idle_slots <= sat_inc(stat_idle_slots);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_responder.sv
// tb/tb_sram_port_responder.sv - directed and randomized bench with a transaction-level reference model

module tb_sram_port_responder;
    import sram_if_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int MW = 18;
    localparam int LAT = 1;

    logic          clock;
    logic          reset;
    logic          refresh;
    logic [MW-1:0] sram_addr;
    logic          sram_we;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic          protocol_error;
`ifdef SRAM_PORT_RESPONDER_STATS_EN
    logic [31:0]   stat_reads;
    logic [31:0]   stat_writes;
    logic [31:0]   stat_idle_slots;
`endif

    sram_port_responder_if #(.ADDRESS_WIDTH(AW), .SRAMDATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    sram_port_responder #(
        .ADDRESS_WIDTH(AW), .SRAMDATA_WIDTH(DW), .TAG_WIDTH(TW),
        .MEM_ADDR_WIDTH(MW), .SRAM_LATENCY(LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .refresh        (refresh),
        .bus            (bus),
        .sram_addr      (sram_addr),
        .sram_we        (sram_we),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata),
        .protocol_error (protocol_error)
`ifdef SRAM_PORT_RESPONDER_STATS_EN
        ,
        .stat_reads      (stat_reads),
        .stat_writes     (stat_writes),
        .stat_idle_slots (stat_idle_slots)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int unsigned a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Environment SRAM: single port, write-first, LAT=1 read register.
    logic [31:0] sram_mem [int unsigned];
    always @(posedge clock) begin
        if (sram_we === 1'b1) sram_mem[int'(sram_addr)] = sram_wdata;
        sram_rdata <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : init_word(int'(sram_addr));
    end

    // ---------------- reference model state ----------------
    typedef struct {
        int        due;
        ret_word_t w;
    } exp_t;

    logic [31:0] ref_mem [int unsigned];
    exp_t        m_q [$];
    bit          m_ready0 = 0, m_ready1 = 0, m_slot0 = 0, m_slot1 = 0;
    int          m_prio = 0;
    bit          m_perr = 0, m_we = 0, m_zero = 1;
    logic [MW-1:0] m_addr = '0;
    int          n_reads = 0, n_writes = 0, n_idle = 0;
    int          cyc = 0;
    int          pulses = 0;
    logic [31:0] last_q = '0;

    // stimulus for the current cycle
    bit          s_rst, s_rfs, s_req0, s_req1, s_ce0, s_ce1, s_we1;
    logic [31:0] s_a0, s_a1, s_wd;
    logic [1:0]  s_tag;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ref_read(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s_rst = 0; s_rfs = 0; s_req0 = 0; s_req1 = 0; s_ce0 = 0; s_ce1 = 0; s_we1 = 0;
        s_a0 = '0; s_a1 = '0; s_wd = '0; s_tag = '0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model, move past the next posedge.
    task automatic tick();
        bit          acc_r, acc_w, g0, g1;
        int unsigned a;
        reset = s_rst; refresh = s_rfs;
        bus.request0 = s_req0; bus.request1 = s_req1;
        bus.command_entry0 = s_ce0; bus.command_entry1 = s_ce1; bus.write_enable1 = s_we1;
        bus.address0 = s_a0; bus.address1 = s_a1; bus.data_out1 = s_wd; bus.tag0 = s_tag;
        @(negedge clock);
        chk("ready0", bus.ready0, m_ready0);
        chk("ready1", bus.ready1, m_ready1);
        chk("ready_exclusive", bus.ready0 & bus.ready1, 0);
        chk("protocol_error", protocol_error, m_perr);
        chk("sram_we", sram_we, m_we);
        chk("sram_addr", sram_addr, m_addr);
        if (bus.valid0 === 1'b1) begin
            pulses++;
            last_q = bus.query0;
        end
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            chk("valid0", bus.valid0, 1);
            chk("query0", bus.query0, m_q[0].w.data);
            chk("qtag0", bus.qtag0, m_q[0].w.tag);
            void'(m_q.pop_front());
        end else begin
            chk("valid0_idle", bus.valid0, 0);
        end
        if (m_zero) begin
            chk("query0_cleared", bus.query0, 0);
            chk("qtag0_cleared", bus.qtag0, 0);
            chk("sram_wdata_cleared", sram_wdata, 0);
        end
`ifdef SRAM_PORT_RESPONDER_STATS_EN
        chk("stat_reads", stat_reads, n_reads);
        chk("stat_writes", stat_writes, n_writes);
        chk("stat_idle_slots", stat_idle_slots, n_idle);
`endif
        if (s_rst || s_rfs) begin
            m_ready0 = 0; m_ready1 = 0; m_slot0 = 0; m_slot1 = 0; m_prio = 0;
            m_perr = 0; m_we = 0; m_addr = '0; m_zero = 1;
            m_q.delete();
            n_reads = 0; n_writes = 0; n_idle = 0;
        end else begin
            m_zero = 0;
            acc_r = s_ce0 && m_slot0;
            acc_w = s_ce1 && m_slot1 && s_we1;
            if ((s_ce0 && !m_slot0) || (s_ce1 && !m_slot1)) m_perr = 1;
            if ((m_slot0 && !s_ce0) || (m_slot1 && !s_ce1)) n_idle++;
            m_we = acc_w;
            if (acc_r) begin
                a = int'(s_a0[MW-1:0]);
                m_addr = s_a0[MW-1:0];
                m_q.push_back('{due: cyc + LAT + 2, w: '{tag: s_tag, data: ref_read(a)}});
                n_reads++;
            end
            if (acc_w) begin
                a = int'(s_a1[MW-1:0]);
                m_addr = s_a1[MW-1:0];
                ref_mem[a] = s_wd;
                n_writes++;
            end
            g0 = s_req0 && (!s_req1 || m_prio == 0);
            g1 = s_req1 && (!s_req0 || m_prio == 1);
            m_slot0 = m_ready0; m_slot1 = m_ready1;
            m_ready0 = g0; m_ready1 = g1;
            if (g0) m_prio = 1;
            else if (g1) m_prio = 0;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int n, base;
        bit wrote, rd;

        idle_inputs();
        s_rst = 1;
        reset = 1; refresh = 0;
        bus.request0 = 0; bus.request1 = 0; bus.command_entry0 = 0; bus.command_entry1 = 0;
        bus.write_enable1 = 0; bus.address0 = '0; bus.address1 = '0; bus.data_out1 = '0; bus.tag0 = '0;
        @(posedge clock);
        #1;
        tick();                                  // reset state observed
        s_rst = 0;

        // 1: port 0 alone, reads of 0..7 in every slot
        base = pulses; n = 0;
        for (int i = 0; i < 10; i++) begin
            s_req0 = (i < 9);
            s_ce0 = m_slot0 && n < 8;
            s_a0 = n;
            s_tag = (n == 7) ? DATA_TAG1 : DATA_TAG0;
            if (s_ce0) n++;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        chk("t1_pulses", pulses - base, 8);

        // 2: both ports request, no commands
        s_req0 = 1; s_req1 = 1;
        for (int i = 0; i < 10; i++) tick();
        idle_inputs();
        tick(); tick();

        // 3: write DEADBEEF at 5, read it back in the next slot
        wrote = 0; rd = 0;
        for (int i = 0; i < 12; i++) begin
            s_req0 = 1; s_req1 = 1; s_ce0 = 0; s_ce1 = 0; s_we1 = 0;
            if (m_slot1 && !wrote) begin
                s_ce1 = 1; s_we1 = 1; s_a1 = 32'h0000_0005; s_wd = 32'hDEAD_BEEF; wrote = 1;
            end else if (m_slot0 && wrote && !rd) begin
                s_ce0 = 1; s_a0 = 32'hABC0_0005; s_tag = DATA_END_TAG; rd = 1;
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        chk("t3_read_after_write", last_q, 32'hDEAD_BEEF);

        // 4: stray command sets sticky protocol_error until refresh
        for (int i = 0; i < 3; i++) tick();
        s_ce0 = 1; s_a0 = 32'h0000_0033;
        tick();
        s_ce0 = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("t4_perr_sticky", protocol_error, 1);
        s_rfs = 1; tick(); s_rfs = 0;
        tick();
        chk("t4_perr_cleared", protocol_error, 0);

        // 5: three reads then reset; nothing returns afterwards
        n = 0;
        for (int i = 0; i < 10 && n < 3; i++) begin
            s_req0 = 1;
            s_ce0 = m_slot0;
            s_a0 = 20 + n;
            s_tag = DATA_TAG0;
            if (s_ce0) n++;
            tick();
        end
        idle_inputs();
        s_rst = 1; tick(); s_rst = 0;
        base = pulses;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_no_return_after_reset", pulses - base, 0);

        // 6: 4 reads, 2 writes, 3 unused slots after a refresh
        s_rfs = 1; tick(); s_rfs = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            s_req0 = (i < 7);
            s_ce0 = m_slot0 && n < 4;
            s_a0 = 60 + n;
            if (s_ce0) n++;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            s_req1 = (i < 2);
            s_ce1 = m_slot1; s_we1 = 1;
            s_a1 = 70 + i; s_wd = $urandom;
            tick();
        end
        idle_inputs();
        tick(); tick();
`ifdef SRAM_PORT_RESPONDER_STATS_EN
        chk("t6_stat_reads", stat_reads, 4);
        chk("t6_stat_writes", stat_writes, 2);
        chk("t6_stat_idle_slots", stat_idle_slots, 3);
`endif
        for (int i = 0; i < 4; i++) tick();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            s_req0 = ($urandom_range(0, 3) != 0);
            s_req1 = ($urandom_range(0, 1) != 0);
            s_ce0  = m_slot0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0);
            s_ce1  = m_slot1 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 59) == 0);
            s_we1  = ($urandom_range(0, 3) != 0);
            s_a0   = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 15));
            s_a1   = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 15));
            s_tag  = 2'($urandom_range(0, 3));
            s_wd   = $urandom;
            s_rfs  = ($urandom_range(0, 79) == 0);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
